alu_control_mc: RTL and testbench
=================================

// Module: alu_control_mc
// PURPOSE
//  Next-generation EX-stage ALU controller. Decodes ALUOp/opcode to the 4-bit ALU control code,
//  as its single-cycle predecessor does. Adds LEGv8 MUL (11'h4D8) and UDIV (11'h4D6), which are
//  executed on an internal iterative datapath. While that datapath runs, the block stalls the pipeline.
//  Sits between ID/EX register and EX result mux; mc_result feeds the EX mux when alu_ctrl is ALU_MUL/ALU_UDIV.
// PARAMETERS
//  DATA_W       64  operand/result width (multiple of MUL_BPC, >=8)
//  MUL_BPC      1   multiplier bits retired per cycle (1,2,4); MUL latency N_MUL = DATA_W/MUL_BPC
//  CTRL_W       4   ALU control code width
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  alu_op       in   2        from ID/EX: 00 ld/st, 01 cbz, 10 R-type, 11 I-type
//  opcode       in   11       instruction[31:21]
//  ex_valid     in   1        valid instruction present in EX this cycle
//  flush        in   1        kill EX instruction (branch taken/exception)
//  op_a         in   DATA_W   Rn value
//  op_b         in   DATA_W   Rm value
//  alu_ctrl     out  CTRL_W   combinational decode result
//  is_multi     out  1        combinational: decoded op is MUL or UDIV
//  stall        out  1        hold IF/ID/EX; freeze ID/EX register
//  mc_valid     out  1        one-cycle pulse: mc_result valid for the EX instruction
//  mc_result    out  DATA_W   MUL low product / UDIV quotient, held until next accept
//  div_by_zero  out  1        pulses with mc_valid when UDIV divisor was 0
// BEHAVIOUR
//  Decode (combinational): 00->ALU_ADD; 01->ALU_PASS_INPUT_B; 10: 458 ADD, 658 SUB, 450 AND, 550 ORR,
//   650 EOR, 69B LSL, 69A LSR, 4D8 ALU_MUL, 4D6 ALU_UDIV, else NOP; 11 on opcode[10:1]: 1001000100 ADD,
//   1001001000 AND, 1011001000 ORR, 1101000100 SUB, else NOP (explicit default, no latch).
//  FSM states IDLE, MUL, DIV, DONE; reset -> IDLE, mc_result=0, mc_valid=0, div_by_zero=0, counter=0.
//  IDLE: ex_valid & is_multi & ~flush -> accept. Latch op_a/op_b, counter=N-1, and go to MUL or DIV.
//   stall=1 combinationally in the accept cycle.
//   UDIV with op_b==0 -> DONE directly; mc_result=0, div_by_zero=1 in DONE.
//  MUL: shift-add, MUL_BPC bits/cycle, N_MUL cycles; result = (a*b) mod 2^DATA_W. stall=1.
//  DIV: restoring, 1 bit/cycle, DATA_W cycles, unsigned quotient; remainder discarded. stall=1.
//  Counter reaching 0 in MUL/DIV -> DONE next edge.
//  DONE: stall=0, mc_valid=1 for exactly this cycle; mc_result registered on DONE entry. EX advances
//   at end of DONE; next state IDLE, never re-accepts the same instruction.
//  Stall high for N+1 cycles (accept + N iterations). EX occupancy N+2 cycles: MUL N=N_MUL, UDIV N=DATA_W.
//  flush in any state: next state IDLE, no mc_valid/div_by_zero pulse, mc_result unchanged, stall=0
//   in that cycle.
//  flush and accept in the same IDLE cycle: flush wins, no accept.
//  Reset mid-operation: immediate return to IDLE with reset values; partial result discarded.
//  Single-cycle ops never assert stall; stall depends on state and the IDLE accept term only.
//  No combinational path from mc_result to stall.
// STRUCTURE
//  defines.vh gains `ALU_MUL, `ALU_UDIV (distinct from existing codes) and `OPC_MUL 11'h4D8,
//   `OPC_UDIV 11'h4D6; FSM state encodings are localparams.
//  Sub-module alu_mc_datapath: operand/accumulator/quotient registers plus shift-add/restoring step
//   logic, driven by start/op_sel/step.
//  The top holds decode, FSM, counter and handshake.
// TESTING
//  1 R-type sweep: alu_op=10 with 458/658/450/550/650/69B/69A -> ADD/SUB/AND/ORR/EOR/LSL/LSR;
//    7FF -> NOP; stall stays 0.
//  2 MUL 7*6, MUL_BPC=1, DATA_W=64: stall high 65 cycles, then mc_valid=1 with mc_result=42 for 1 cycle.
//  3 UDIV 100/7: stall high 65 cycles, then mc_result=14, div_by_zero=0.
//    UDIV 2^64-1 / 1 -> 2^64-1.
//  4 UDIV 5/0: accept cycle stalls, then DONE next cycle with mc_result=0 and div_by_zero=1.
//  5 flush at iteration 10 of a MUL: next cycle IDLE, no mc_valid; back-to-back MUL then accepts normally.
//  6 reset asserted mid-DIV, asynchronously between edges: outputs zero immediately.
//    Also, alu_op=11 with opcode 1101000100x -> ALU_SUB, and an unmatched I-type opcode -> NOP.

Source files
------------

// File: rtl/alu_control_mc_pkg.sv
// Shared ALU control codes, LEGv8 opcodes, controller state encodings and the
// single-cycle decode used by the EX-stage ALU controller.
package alu_control_mc_pkg;

    localparam logic [3:0] ALU_AND          = 4'b0000;
    localparam logic [3:0] ALU_ORR          = 4'b0001;
    localparam logic [3:0] ALU_ADD          = 4'b0010;
    localparam logic [3:0] ALU_EOR          = 4'b0011;
    localparam logic [3:0] ALU_LSL          = 4'b0100;
    localparam logic [3:0] ALU_LSR          = 4'b0101;
    localparam logic [3:0] ALU_SUB          = 4'b0110;
    localparam logic [3:0] ALU_PASS_INPUT_B = 4'b0111;
    localparam logic [3:0] ALU_MUL          = 4'b1000;
    localparam logic [3:0] ALU_UDIV         = 4'b1001;
    localparam logic [3:0] ALU_NOP          = 4'b1111;

    localparam logic [10:0] OPC_ADD  = 11'h458;
    localparam logic [10:0] OPC_SUB  = 11'h658;
    localparam logic [10:0] OPC_AND  = 11'h450;
    localparam logic [10:0] OPC_ORR  = 11'h550;
    localparam logic [10:0] OPC_EOR  = 11'h650;
    localparam logic [10:0] OPC_LSL  = 11'h69B;
    localparam logic [10:0] OPC_LSR  = 11'h69A;
    localparam logic [10:0] OPC_MUL  = 11'h4D8;
    localparam logic [10:0] OPC_UDIV = 11'h4D6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MUL  = ST_MUL,
        S_DIV  = ST_DIV,
        S_DONE = ST_DONE
    } mc_state_e;

    function automatic logic [3:0] alu_decode(input logic [1:0] alu_op, input logic [10:0] opc);
        logic [3:0] code;
        code = ALU_NOP;
        case (alu_op)
            2'b00: code = ALU_ADD;
            2'b01: code = ALU_PASS_INPUT_B;
            2'b10: begin
                case (opc)
                    OPC_ADD:  code = ALU_ADD;
                    OPC_SUB:  code = ALU_SUB;
                    OPC_AND:  code = ALU_AND;
                    OPC_ORR:  code = ALU_ORR;
                    OPC_EOR:  code = ALU_EOR;
                    OPC_LSL:  code = ALU_LSL;
                    OPC_LSR:  code = ALU_LSR;
                    OPC_MUL:  code = ALU_MUL;
                    OPC_UDIV: code = ALU_UDIV;
                    default:  code = ALU_NOP;
                endcase
            end
            default: begin
                // I-type immediates occupy opcode[0], so only the upper ten bits select the op
                case (opc[10:1])
                    10'b1001000100: code = ALU_ADD;
                    10'b1001001000: code = ALU_AND;
                    10'b1011001000: code = ALU_ORR;
                    10'b1101000100: code = ALU_SUB;
                    default:        code = ALU_NOP;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_control_mc_datapath.sv
// Iterative datapath for MUL (shift-add, MUL_BPC bits per step) and UDIV
// (restoring, one quotient bit per step). res_nxt_o is the result after the current step.
module alu_mc_datapath #(
    parameter int DATA_W  = 64,
    parameter int MUL_BPC = 1
) (
    input  logic              clk,
    input  logic              start_i,
    input  logic              op_sel_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_nxt_o
);

    // MUL: x = shifting multiplicand, y = shifting multiplier, acc = product
    // UDIV: x = divisor, y = dividend shifting into quotient, acc = remainder
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] acc_q;

    logic [DATA_W-1:0] partial;
    logic [DATA_W-1:0] mul_acc;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] div_rem;
    logic [DATA_W-1:0] div_quo;

    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_BPC; j++) begin
            if (y_q[j]) partial = partial + (x_q << j);
        end
        mul_acc = acc_q + partial;

        rem_sh = {acc_q, y_q[DATA_W-1]};
        trial  = rem_sh - {1'b0, x_q};
        if (!trial[DATA_W]) begin
            div_rem = trial[DATA_W-1:0];
            div_quo = {y_q[DATA_W-2:0], 1'b1};
        end else begin
            div_rem = rem_sh[DATA_W-1:0];
            div_quo = {y_q[DATA_W-2:0], 1'b0};
        end
    end

    assign res_nxt_o = op_sel_i ? div_quo : mul_acc;

    always_ff @(posedge clk) begin
        if (start_i) begin
            x_q   <= op_sel_i ? b_i : a_i;
            y_q   <= op_sel_i ? a_i : b_i;
            acc_q <= '0;
        end else if (step_i) begin
            if (op_sel_i) begin
                acc_q <= div_rem;
                y_q   <= div_quo;
            end else begin
                acc_q <= mul_acc;
                x_q   <= x_q << MUL_BPC;
                y_q   <= y_q >> MUL_BPC;
            end
        end
    end

endmodule

// File: rtl/alu_control_mc.sv
// EX-stage ALU controller: combinational opcode decode plus a multi-cycle
// MUL/UDIV sequencer that stalls the pipeline while the iterative datapath runs.
module alu_control_mc
    import alu_control_mc_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int MUL_BPC = 1,
    parameter int CTRL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        alu_op,
    input  logic [10:0]       opcode,
    input  logic              ex_valid,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              is_multi,
    output logic              stall,
    output logic              mc_valid,
    output logic [DATA_W-1:0] mc_result,
    output logic              div_by_zero
);

    localparam int N_MUL = DATA_W / MUL_BPC;
    localparam int CNT_W = $clog2(DATA_W);

    mc_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mc_valid_q;
    logic              dbz_q;
    logic [DATA_W-1:0] mc_result_q;

    logic [3:0]        ctrl_dec;
    logic              is_udiv;
    logic              accept;
    logic              dp_op_sel;
    logic              dp_step;
    logic [DATA_W-1:0] dp_res_nxt;

    assign ctrl_dec = alu_decode(alu_op, opcode);
    assign alu_ctrl = CTRL_W'(ctrl_dec);
    assign is_udiv  = (ctrl_dec == ALU_UDIV);
    assign is_multi = (ctrl_dec == ALU_MUL) || is_udiv;

    // Reset gates the accept term so stall drops the instant reset is asserted
    assign accept = (state_q == S_IDLE) && ex_valid && is_multi && !flush && !reset;

    assign stall = !flush && (accept || state_q == S_MUL || state_q == S_DIV);

    assign mc_valid    = mc_valid_q && !flush;
    assign div_by_zero = dbz_q && !flush;
    assign mc_result   = mc_result_q;

    assign dp_op_sel = (state_q == S_IDLE) ? is_udiv : (state_q == S_DIV);
    assign dp_step   = (state_q == S_MUL) || (state_q == S_DIV);

    alu_mc_datapath #(
        .DATA_W  (DATA_W),
        .MUL_BPC (MUL_BPC)
    ) u_dp (
        .clk       (clk),
        .start_i   (accept),
        .op_sel_i  (dp_op_sel),
        .step_i    (dp_step),
        .a_i       (op_a),
        .b_i       (op_b),
        .res_nxt_o (dp_res_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mc_valid_q  <= 1'b0;
            dbz_q       <= 1'b0;
            mc_result_q <= '0;
        end else begin
            mc_valid_q <= 1'b0;
            dbz_q      <= 1'b0;
            if (flush) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            if (is_udiv && op_b == '0) begin
                                state_q     <= S_DONE;
                                mc_result_q <= '0;
                                mc_valid_q  <= 1'b1;
                                dbz_q       <= 1'b1;
                            end else if (is_udiv) begin
                                state_q <= S_DIV;
                                cnt_q   <= CNT_W'(DATA_W - 1);
                            end else begin
                                state_q <= S_MUL;
                                cnt_q   <= CNT_W'(N_MUL - 1);
                            end
                        end
                    end
                    S_MUL, S_DIV: begin
                        if (cnt_q == '0) begin
                            state_q     <= S_DONE;
                            mc_result_q <= dp_res_nxt;
                            mc_valid_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_control_mc.sv
// Directed bench for alu_control_mc: decode tables, MUL/UDIV latency and
// results, divide-by-zero, flush and asynchronous reset behaviour.
module tb_alu_control_mc;

    logic        clk;
    logic        reset;
    logic [1:0]  alu_op;
    logic [10:0] opcode;
    logic        ex_valid;
    logic        flush;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic [3:0]  alu_ctrl;
    logic        is_multi;
    logic        stall;
    logic        mc_valid;
    logic [63:0] mc_result;
    logic        div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    alu_control_mc #(
        .DATA_W  (64),
        .MUL_BPC (1),
        .CTRL_W  (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_op      (alu_op),
        .opcode      (opcode),
        .ex_valid    (ex_valid),
        .flush       (flush),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_ctrl    (alu_ctrl),
        .is_multi    (is_multi),
        .stall       (stall),
        .mc_valid    (mc_valid),
        .mc_result   (mc_result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches a MUL/UDIV, counts stall cycles and checks the DONE cycle.
    task automatic run_multi(input string tag, input logic [10:0] opc, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] exp_res,
                             input int exp_cycles, input logic exp_dbz);
        int n;
        alu_op   = 2'b10;
        opcode   = opc;
        op_a     = a;
        op_b     = b;
        ex_valid = 1'b1;
        #1;
        n = 0;
        while (stall === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'(exp_cycles));
        check({tag, "_valid"}, {63'b0, mc_valid}, 64'd1);
        check({tag, "_result"}, mc_result, exp_res);
        check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, exp_dbz});
        ex_valid = 1'b0;
        tick();
        check({tag, "_valid_drop"}, {63'b0, mc_valid}, 64'd0);
        check({tag, "_result_hold"}, mc_result, exp_res);
    endtask

    logic [10:0] r_opc [7];
    logic [3:0]  r_exp [7];
    logic [63:0] prev_res;

    initial begin
        r_opc = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h650, 11'h69B, 11'h69A};
        r_exp = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101};

        reset    = 1'b1;
        alu_op   = 2'b00;
        opcode   = 11'h0;
        ex_valid = 1'b0;
        flush    = 1'b0;
        op_a     = '0;
        op_b     = '0;
        #12;
        check("rst_result", mc_result, 64'd0);
        check("rst_valid", {63'b0, mc_valid}, 64'd0);
        check("rst_stall", {63'b0, stall}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Decode sweep with a valid single-cycle instruction present
        ex_valid = 1'b1;
        alu_op   = 2'b10;
        for (int i = 0; i < 7; i++) begin
            opcode = r_opc[i];
            #1;
            check($sformatf("rtype_%0h", r_opc[i]), {60'b0, alu_ctrl}, {60'b0, r_exp[i]});
            check($sformatf("rtype_stall_%0h", r_opc[i]), {63'b0, stall}, 64'd0);
            tick();
        end
        opcode = 11'h7FF;
        #1;
        check("rtype_nop", {60'b0, alu_ctrl}, 64'hF);
        check("rtype_nop_stall", {63'b0, stall}, 64'd0);
        opcode = 11'h4D8;
        #1;
        check("rtype_mul", {60'b0, alu_ctrl}, 64'h8);
        check("is_multi_mul", {63'b0, is_multi}, 64'd1);
        opcode = 11'h4D6;
        #1;
        check("rtype_udiv", {60'b0, alu_ctrl}, 64'h9);
        alu_op = 2'b11;
        opcode = 11'b11010001001;
        #1;
        check("itype_sub", {60'b0, alu_ctrl}, 64'h6);
        opcode = 11'b10010001000;
        #1;
        check("itype_add", {60'b0, alu_ctrl}, 64'h2);
        opcode = 11'b11111111110;
        #1;
        check("itype_nop", {60'b0, alu_ctrl}, 64'hF);
        check("itype_nop_multi", {63'b0, is_multi}, 64'd0);
        alu_op = 2'b00;
        #1;
        check("ldst_add", {60'b0, alu_ctrl}, 64'h2);
        alu_op = 2'b01;
        #1;
        check("cbz_passb", {60'b0, alu_ctrl}, 64'h7);
        ex_valid = 1'b0;
        tick();

        run_multi("mul_7x6", 11'h4D8, 64'd7, 64'd6, 64'd42, 65, 1'b0);
        run_multi("udiv_100_7", 11'h4D6, 64'd100, 64'd7, 64'd14, 65, 1'b0);
        run_multi("udiv_max_1", 11'h4D6, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run_multi("udiv_5_0", 11'h4D6, 64'd5, 64'd0, 64'd0, 1, 1'b1);
        run_multi("mul_wrap", 11'h4D8, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'd1, 65, 1'b0);

        // Flush during the tenth MUL iteration
        prev_res = mc_result;
        alu_op   = 2'b10;
        opcode   = 11'h4D8;
        op_a     = 64'd9;
        op_b     = 64'd9;
        ex_valid = 1'b1;
        #1;
        check("flush_accept_stall", {63'b0, stall}, 64'd1);
        for (int i = 0; i < 10; i++) tick();
        check("flush_pre_stall", {63'b0, stall}, 64'd1);
        flush    = 1'b1;
        ex_valid = 1'b0;
        #1;
        check("flush_stall_low", {63'b0, stall}, 64'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle_stall", {63'b0, stall}, 64'd0);
        check("flush_no_valid", {63'b0, mc_valid}, 64'd0);
        check("flush_result_kept", mc_result, prev_res);
        for (int i = 0; i < 70; i++) begin
            tick();
            if (mc_valid !== 1'b0) check("flush_late_valid", {63'b0, mc_valid}, 64'd0);
        end
        run_multi("mul_b2b", 11'h4D8, 64'd12345, 64'd6789, 64'd83810205, 65, 1'b0);

        // Asynchronous reset in the middle of a divide
        alu_op   = 2'b10;
        opcode   = 11'h4D6;
        op_a     = 64'd1000;
        op_b     = 64'd3;
        ex_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("div_mid_stall", {63'b0, stall}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_result", mc_result, 64'd0);
        check("arst_stall", {63'b0, stall}, 64'd0);
        check("arst_valid", {63'b0, mc_valid}, 64'd0);
        ex_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("arst_idle_stall", {63'b0, stall}, 64'd0);
        run_multi("udiv_after_rst", 11'h4D6, 64'd1000, 64'd3, 64'd333, 65, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
